// File: rtl/l2_arb_pkg.sv
// Shared widths, field offsets and FSM state type for the L2 arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    INV_WAIT = 2'd2
  } state_e;

  // Request layout is {valid, addr, wdata, wstrb}; response layout is {rdata, ready}.
  localparam int unsigned RESP_READY_BIT = 0;
  localparam int unsigned RESP_RDATA_LSB = 1;

  function automatic int unsigned strb_w(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned req_w(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int unsigned resp_w(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned wdata_lsb(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned dw);
    return dw + dw / 8;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned aw, input int unsigned dw);
    return aw + dw + dw / 8;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Picks the first requesting index at or after ptr, wrapping to the lowest requester.
module rr_pick
  import l2_arb_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;

  // Descending scan: last hit is the lowest index overall and the lowest at/after ptr.
  always_comb begin
    found_c  = 1'b0;
    idx_c    = '0;
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (req[j]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(j);
        if (j >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end
      end
    end
    if (hi_found) idx_c = hi_idx;
  end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates N cache back-ends onto one L2 port and sequences invalidates.
// Define L2ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 256
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_MASTERS*req_w(ADDR_W, DATA_W)-1:0]  m_req,
  output logic [N_MASTERS*resp_w(DATA_W)-1:0]         m_resp,
  output logic [req_w(ADDR_W, DATA_W)-1:0]            s_req,
  input  logic [resp_w(DATA_W)-1:0]                   s_resp,
  input  logic                                        inv_req,
  input  logic                                        wtb_empty,
  output logic                                        inv_out,
  output logic                                        inv_busy
);

  localparam int unsigned REQ_W     = req_w(ADDR_W, DATA_W);
  localparam int unsigned RESP_W    = resp_w(DATA_W);
  localparam int unsigned IDX_W     = idx_w(N_MASTERS);
  localparam int unsigned VALID_BIT = valid_bit(ADDR_W, DATA_W);

  state_e               state;
  logic [IDX_W-1:0]     grant;
  logic                 pending;
  logic [IDX_W-1:0]     ptr;
  logic [N_MASTERS-1:0] valid_vec;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 s_ready;

  assign s_ready  = s_resp[RESP_READY_BIT];
  assign inv_busy = pending;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      valid_vec[i] = m_req[i*REQ_W + VALID_BIT];
    end
  end

`ifdef L2ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // Pointer moves past the master that just completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == GRANT && s_ready) begin
      ptr <= (grant == IDX_W'(N_MASTERS - 1)) ? '0 : grant + IDX_W'(1);
    end
  end
`endif

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .ptr     (ptr),
    .req     (valid_vec),
    .idx_c   (pick_idx),
    .found_c (pick_found)
  );

  // A fresh inv_req in IDLE beats a same-cycle grant decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      pending <= 1'b0;
      inv_out <= 1'b0;
    end else begin
      inv_out <= 1'b0;
      if (inv_req) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (pending || inv_req) begin
            state <= INV_WAIT;
          end else if (pick_found) begin
            grant <= pick_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (s_ready) state <= IDLE;
        end
        INV_WAIT: begin
          if (wtb_empty) begin
            inv_out <= 1'b1;
            pending <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_req = '0;
    if (state == GRANT) begin
      for (int i = 0; i < int'(N_MASTERS); i++) begin
        if (grant == IDX_W'(i)) s_req = m_req[i*REQ_W +: REQ_W];
      end
    end
  end

  // rdata is broadcast; ready only reaches the granted master.
  always_comb begin
    m_resp = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      m_resp[i*RESP_W + RESP_RDATA_LSB +: DATA_W] = s_resp[RESP_RDATA_LSB +: DATA_W];
      m_resp[i*RESP_W + RESP_READY_BIT] = (state == GRANT) && (grant == IDX_W'(i)) && s_ready;
    end
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2: number of requesting cache back-ends, 1..8.
REQ-002 SHALL have parameter ADDR_W, default 30: byte-address width of the native request.
REQ-003 SHALL have parameter DATA_W, default 256: wide-bus data width; wstrb width is DATA_W/8.
REQ-004 SHALL have port clk  input  1  clock, all state updated on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port m_req  input  N_MASTERS*(1+ADDR_W+DATA_W+DATA_W/8)  packed {valid,addr,wdata,wstrb} per master, master 0 in the LSBs.
REQ-007 SHALL have port m_resp  output  N_MASTERS*(DATA_W+1)  packed {rdata,ready} per master.
REQ-008 SHALL have port s_req  output  1+ADDR_W+DATA_W+DATA_W/8  request to L2 cache.
REQ-009 SHALL have port s_resp  input  DATA_W+1  {rdata,ready} from L2 cache.
REQ-010 SHALL have port inv_req  input  1  single-cycle invalidate request from L1 control.
REQ-011 SHALL have port wtb_empty  input  1  L2 write-through buffer empty.
REQ-012 SHALL have port inv_out  output  1  single-cycle invalidate pulse to L2 force_inv_in.
REQ-013 SHALL have port inv_busy  output  1  high while an invalidate is pending.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, INV_WAIT.
REQ-015 IDLE: if inv pending, go to INV_WAIT; else if any master valid, register winner index and go to GRANT next cycle; else stay.
REQ-016 GRANT: s_req SHALL equal the granted master's request (combinational mux); all other fields of s_req zero when not in GRANT.
REQ-017 s_resp.ready SHALL be routed only to the granted master; s_resp.rdata broadcast to all masters; non-granted ready = 0.
REQ-018 GRANT SHALL be held until s_resp.ready=1, then return to IDLE; minimum one IDLE cycle between transactions (arbitration latency 1 cycle).
REQ-019 Round-robin: on completion pointer SHALL become (grant+1) mod N_MASTERS; winner is first valid master at or after pointer.
REQ-020 inv_req SHALL set a pending flag in any state; a second inv_req while pending SHALL be merged (no double pulse).
REQ-021 INV_WAIT: when wtb_empty=1, inv_out=1 for exactly one cycle, pending cleared, return to IDLE; no grant issued while pending.
REQ-022 inv_req simultaneous with a grant decision in IDLE: invalidate SHALL win; masters wait.
REQ-023 inv_req during GRANT: current transaction SHALL complete first.
REQ-024 A master dropping valid while granted is illegal; behaviour unspecified.

Reset
REQ-025 On rst: state IDLE, pointer 0, grant 0, pending 0, inv_out 0, inv_busy 0, s_req 0, all m_resp.ready 0; applies mid-transaction, abandoning it.

Configuration
REQ-026 With L2ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, pointer register removed.
REQ-027 Without L2ARB_FIXED_PRIO_EN: round-robin per REQ-019.

Structure
REQ-028 Request/response widths and field offset constants SHALL live in shared package l2_arb_pkg.
REQ-029 Winner selection SHALL be sub-module rr_pick (pointer, request vector -> index, found).

Verification
REQ-030 N=2, m0 and m1 valid continuously, ready after 3 cycles -> grants alternate 0,1,0,1; each 4 GRANT cycles + 1 IDLE.
REQ-031 Fixed-prio build, both valid -> m0 granted every transaction, m1 starved until m0 drops valid.
REQ-032 inv_req during m1 GRANT, wtb_empty=0 for 5 cycles -> m1 completes, inv_out single pulse 1 cycle after wtb_empty rises, then m0 granted.
REQ-033 inv_req twice 2 cycles apart -> exactly one inv_out pulse.
REQ-034 rst asserted mid-GRANT -> all outputs 0 same cycle; after release, first grant to master 0.
REQ-035 m0 write wstrb=all-ones, addr=0x40 -> s_req bit-identical to m0 request; m1 ready stays 0.
